// File: rtl/rsa_encrypt_seq.sv
// rsa_encrypt_seq: sequential RSA encryption engine, C = P^e mod (p*q).
// Right-to-left square-and-multiply; each modular multiply is an
// interleaved shift-add (MSB first) taking WIDTH cycles, so no wide
// product or divider is built. Also reports n = p*q and phi_n = (p-1)*(q-1).
//
// Build option: define RSA_RANGE_CHECK_EN to flag plaintext P >= n as an
// error. Without it, P is reduced mod n in SETUP by repeated subtraction.
module rsa_encrypt_seq #(
    parameter int WIDTH = 64,
    parameter int PW    = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PW-1:0]    p,
    input  logic [PW-1:0]    q,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] P,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] phi_n,
    output logic [WIDTH-1:0] C
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_BIT   = 3'd2;
    localparam logic [2:0] S_MUL   = 3'd3;
    localparam logic [2:0] S_SQR   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       state;
    logic [PW-1:0]    p_r;
    logic [PW-1:0]    q_r;
    logic [WIDTH-1:0] exp_r;   // remaining exponent, shifted right per SQR
    logic [WIDTH-1:0] base_r;  // P^(2^i) mod n
    logic [WIDTH-1:0] res_r;   // running product
    logic [WIDTH-1:0] mreg;    // multiplier bits, consumed MSB first
    logic [WIDTH:0]   acc;     // partial product, always < n between steps
    logic [CW-1:0]    cnt;     // bit position within one modular multiply

    // Modulus and totient of the latched primes; small PW x PW products.
    logic [PW-1:0]    p_m1;
    logic [PW-1:0]    q_m1;
    logic [2*PW-1:0]  n_prod;
    logic [2*PW-1:0]  phi_prod;
    logic [WIDTH-1:0] n_full;
    logic [WIDTH-1:0] phi_full;
    logic             bad_primes;

    assign p_m1       = p_r - PW'(1);
    assign q_m1       = q_r - PW'(1);
    assign n_prod     = {{PW{1'b0}}, p_r}  * {{PW{1'b0}}, q_r};
    assign phi_prod   = {{PW{1'b0}}, p_m1} * {{PW{1'b0}}, q_m1};
    assign n_full     = {{(WIDTH-2*PW){1'b0}}, n_prod};
    assign phi_full   = {{(WIDTH-2*PW){1'b0}}, phi_prod};
    assign bad_primes = (p_r < PW'(2)) || (q_r < PW'(2));

    // One interleaved step: acc = 2*acc mod n, then acc = acc + base mod n
    // when the current multiplier bit is set. Both sums stay below 2n, so a
    // single conditional subtract of n reduces each one.
    logic [WIDTH:0] n_w;
    logic [WIDTH:0] dbl;
    logic [WIDTH:0] dbl_red;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] sum_red;
    logic [WIDTH:0] acc_next;

    assign n_w      = {1'b0, n};
    assign dbl      = acc << 1;
    assign dbl_red  = (dbl >= n_w) ? (dbl - n_w) : dbl;
    assign sum      = dbl_red + {1'b0, base_r};
    assign sum_red  = (sum >= n_w) ? (sum - n_w) : sum;
    assign acc_next = mreg[WIDTH-1] ? sum_red : dbl_red;

    assign busy = (state == S_SETUP) || (state == S_BIT) ||
                  (state == S_MUL)   || (state == S_SQR);
    assign done = (state == S_DONE);

    // Control FSM, exponentiation datapath and result registers.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all reads see the values from
        // before this edge; mixing in blocking writes would create ordering races.
        if (!rst_n) begin
            state  <= S_IDLE;
            err    <= 1'b0;
            n      <= '0;
            phi_n  <= '0;
            C      <= '0;
            p_r    <= '0;
            q_r    <= '0;
            exp_r  <= '0;
            base_r <= '0;
            res_r  <= '0;
            mreg   <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        p_r    <= p;
                        q_r    <= q;
                        exp_r  <= e;
                        base_r <= P;
                        state  <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    n     <= n_full;
                    phi_n <= phi_full;
                    if (bad_primes) begin
                        err   <= 1'b1;
                        C     <= '0;
                        state <= S_DONE;
                    end
`ifdef RSA_RANGE_CHECK_EN
                    else if (base_r >= n_full) begin
                        // Plaintext out of range: reject without exponentiating.
                        err   <= 1'b1;
                        C     <= '0;
                        state <= S_DONE;
                    end
`else
                    else if (base_r >= n_full) begin
                        // Reduce P mod n one subtract per cycle; stay in SETUP.
                        base_r <= base_r - n_full;
                    end
`endif
                    else begin
                        err   <= 1'b0;
                        res_r <= (n_full == WIDTH'(1)) ? '0 : WIDTH'(1);
                        state <= S_BIT;
                    end
                end

                S_BIT: begin
                    if (exp_r == '0) begin
                        C     <= res_r;
                        state <= S_DONE;
                    end else begin
                        acc   <= '0;
                        cnt   <= '0;
                        mreg  <= exp_r[0] ? res_r : base_r;
                        state <= exp_r[0] ? S_MUL : S_SQR;
                    end
                end

                S_MUL: begin
                    // res = res * base mod n; then always square.
                    acc  <= acc_next;
                    mreg <= mreg << 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        res_r <= acc_next[WIDTH-1:0];
                        acc   <= '0;
                        cnt   <= '0;
                        mreg  <= base_r;
                        state <= S_SQR;
                    end
                end

                S_SQR: begin
                    // base = base * base mod n, even on the final bit where
                    // the squared value is no longer needed.
                    acc  <= acc_next;
                    mreg <= mreg << 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        base_r <= acc_next[WIDTH-1:0];
                        exp_r  <= exp_r >> 1;
                        state  <= S_BIT;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_encrypt_seq.sv
// Self-checking bench for rsa_encrypt_seq: a scoreboard queue receives the
// expected result when a start is driven and is popped when done pulses.
// Expected values under RSA_RANGE_CHECK_EN follow the same macro.
module tb_rsa_encrypt_seq;

    localparam int WIDTH   = 64;
    localparam int PW      = 9;
    localparam int TIMEOUT = 5000;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [PW-1:0]    p     = '0;
    logic [PW-1:0]    q     = '0;
    logic [WIDTH-1:0] e     = '0;
    logic [WIDTH-1:0] P     = '0;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] phi_n;
    logic [WIDTH-1:0] C;

    always #5 clk = ~clk;

    rsa_encrypt_seq #(.WIDTH(WIDTH), .PW(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .p     (p),
        .q     (q),
        .e     (e),
        .P     (P),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .n     (n),
        .phi_n (phi_n),
        .C     (C)
    );

    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] n;
        logic [WIDTH-1:0] phi;
        logic [WIDTH-1:0] c;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic res_t mk(input logic er, input longint unsigned nn,
                                input longint unsigned ph, input longint unsigned cc);
        res_t r;
        r.err = er;
        r.n   = nn;
        r.phi = ph;
        r.c   = cc;
        return r;
    endfunction

    // Reference: direct modular arithmetic on small moduli (products fit 64 bits).
    function automatic res_t model(input int pp, input int qq,
                                   input longint unsigned ee, input longint unsigned pt);
        res_t m;
        longint unsigned nn, b, r, x;
        nn    = longint'(pp) * longint'(qq);
        m.n   = nn;
        m.phi = longint'(pp - 1) * longint'(qq - 1);
        m.err = 1'b0;
        m.c   = '0;
        if (pp < 2 || qq < 2) begin
            m.err = 1'b1;
            return m;
        end
        b = pt;
        if (b >= nn) begin
`ifdef RSA_RANGE_CHECK_EN
            m.err = 1'b1;
            return m;
`else
            b = b % nn;
`endif
        end
        r = (nn == 1) ? 0 : 1;
        x = ee;
        while (x != 0) begin
            if (x[0]) r = (r * b) % nn;
            b = (b * b) % nn;
            x = x >> 1;
        end
        m.c = r;
        return m;
    endfunction

    // Drive one start pulse and record the expected result.
    task automatic issue(input int pp, input int qq, input logic [WIDTH-1:0] ee,
                         input logic [WIDTH-1:0] pt, input res_t ex);
        @(negedge clk);
        p     = pp[PW-1:0];
        q     = qq[PW-1:0];
        e     = ee;
        P     = pt;
        start = 1'b1;
        exp_q.push_back(ex);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; lat counts cycles including the start cycle.
    task automatic collect(output res_t obs, output int lat, output bit ok);
        ok  = 1'b0;
        lat = 1;
        obs = '0;
        while (lat <= TIMEOUT) begin
            if (done === 1'b1) begin
                ok  = 1'b1;
                obs = {err, n, phi_n, C};
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, err, n, phi_n, C} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%0d done=%0d err=%0d n=%0d phi=%0d C=%0d, want all 0",
                     busy, done, err, n, phi_n, C);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        res_t obs, ex;
        int lat;
        bit ok;
        issue(61, 53, 64'd17, 64'd65, mk(1'b0, 3233, 3120, 2790));
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_busy: busy=%0d, want 1", busy);
        end
        collect(obs, lat, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL basic_timeout: no done in %0d cycles", TIMEOUT);
        end else begin
            ex = exp_q.pop_front();
            if (obs !== ex) begin
                n_bad++;
                $display("FAIL basic_result: got err=%0d n=%0d phi=%0d C=%0d, want err=%0d n=%0d phi=%0d C=%0d",
                         obs.err, obs.n, obs.phi, obs.c, ex.err, ex.n, ex.phi, ex.c);
            end
            n_cmp++;
            if (lat > 3 + 5 * (2 * WIDTH + 1)) begin
                n_bad++;
                $display("FAIL basic_latency: %0d cycles, want <= %0d", lat, 3 + 5 * (2 * WIDTH + 1));
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL basic_done_pulse: done=%0d busy=%0d one cycle later, want 0 0", done, busy);
            end
        end
    endtask

    task automatic test_loopback();
        res_t obs, ex;
        int lat;
        bit ok;
        logic [WIDTH-1:0] ct;
        issue(3, 11, 64'd7, 64'd2, mk(1'b0, 33, 20, 29));
        collect(obs, lat, ok);
        n_cmp++;
        ct = obs.c;
        if (!ok) begin
            n_bad++;
            $display("FAIL loop_enc_timeout: no done in %0d cycles", TIMEOUT);
        end else begin
            ex = exp_q.pop_front();
            if (obs !== ex) begin
                n_bad++;
                $display("FAIL loop_enc: got err=%0d n=%0d phi=%0d C=%0d, want err=%0d n=%0d phi=%0d C=%0d",
                         obs.err, obs.n, obs.phi, obs.c, ex.err, ex.n, ex.phi, ex.c);
            end
        end
        // Decrypt with d=3: same modexp on the ciphertext must recover P=2.
        issue(3, 11, 64'd3, ct, mk(1'b0, 33, 20, 2));
        collect(obs, lat, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL loop_dec_timeout: no done in %0d cycles", TIMEOUT);
        end else begin
            ex = exp_q.pop_front();
            if (obs !== ex) begin
                n_bad++;
                $display("FAIL loop_dec: got err=%0d C=%0d, want err=%0d C=%0d", obs.err, obs.c, ex.err, ex.c);
            end
        end
    endtask

    task automatic test_boundaries();
        res_t obs, ex;
        int lat;
        bit ok;
        logic [WIDTH-1:0] ee [2] = '{64'd0, 64'd17};
        logic [WIDTH-1:0] pt [2] = '{64'd65, 64'd0};
        longint unsigned  cc [2] = '{1, 0};
        for (int i = 0; i < 2; i++) begin
            issue(61, 53, ee[i], pt[i], mk(1'b0, 3233, 3120, cc[i]));
            collect(obs, lat, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL boundary_%0d_timeout: no done", i);
            end else begin
                ex = exp_q.pop_front();
                if (obs !== ex) begin
                    n_bad++;
                    $display("FAIL boundary_%0d: got err=%0d C=%0d, want err=%0d C=%0d",
                             i, obs.err, obs.c, ex.err, ex.c);
                end
            end
        end
    endtask

    task automatic test_err();
        res_t obs, ex;
        int lat;
        bit ok;
        int pl [2] = '{1, 61};
        int ql [2] = '{53, 1};
        for (int i = 0; i < 2; i++) begin
            issue(pl[i], ql[i], 64'd17, 64'd5, mk(1'b1, pl[i] * ql[i], 0, 0));
            collect(obs, lat, ok);
            n_cmp++;
            if (!ok || lat > 3) begin
                n_bad++;
                $display("FAIL err_%0d_latency: ok=%0d lat=%0d, want done within 3", i, ok, lat);
            end else begin
                ex = exp_q.pop_front();
                n_cmp++;
                if (obs !== ex) begin
                    n_bad++;
                    $display("FAIL err_%0d: got err=%0d n=%0d phi=%0d C=%0d, want err=%0d n=%0d phi=%0d C=%0d",
                             i, obs.err, obs.n, obs.phi, obs.c, ex.err, ex.n, ex.phi, ex.c);
                end
            end
        end
    endtask

    task automatic test_range();
        res_t obs, ex;
        int lat;
        bit ok;
`ifdef RSA_RANGE_CHECK_EN
        ex = mk(1'b1, 3233, 3120, 0);
`else
        ex = mk(1'b0, 3233, 3120, 67);
`endif
        issue(61, 53, 64'd1, 64'd3300, ex);
        collect(obs, lat, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL range_timeout: no done");
        end else begin
            ex = exp_q.pop_front();
            if (obs !== ex) begin
                n_bad++;
                $display("FAIL range: got err=%0d C=%0d, want err=%0d C=%0d", obs.err, obs.c, ex.err, ex.c);
            end
        end
    endtask

    task automatic test_ignore_start();
        res_t obs, ex;
        int lat;
        bit ok;
        int extra;
        issue(61, 53, 64'd17, 64'd65, mk(1'b0, 3233, 3120, 2790));
        // Two stray starts while busy (SETUP/BIT region, then mid-multiply).
        for (int k = 0; k < 2; k++) begin
            repeat (k == 0 ? 1 : 150) @(negedge clk);
            p = 9'd3; q = 9'd11; e = 64'd7; P = 64'd2;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        collect(obs, lat, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL ignore_timeout: no done");
        end else begin
            ex = exp_q.pop_front();
            if (obs !== ex) begin
                n_bad++;
                $display("FAIL ignore_result: got C=%0d n=%0d, want C=%0d n=%0d", obs.c, obs.n, ex.c, ex.n);
            end
        end
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL ignore_restart: %0d busy/done cycles after the op, want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        res_t obs, ex;
        int lat;
        bit ok;
        issue(61, 53, 64'd17, 64'd65, mk(1'b0, 3233, 3120, 2790));
        repeat (6) @(negedge clk);   // well inside the first MUL
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, err, n, phi_n, C} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: busy=%0d done=%0d err=%0d n=%0d phi=%0d C=%0d, want all 0",
                     busy, done, err, n, phi_n, C);
        end
        rst_n = 1'b1;
        exp_q.delete();
        issue(3, 11, 64'd7, 64'd2, mk(1'b0, 33, 20, 29));
        collect(obs, lat, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL after_reset_timeout: no done");
        end else begin
            ex = exp_q.pop_front();
            if (obs !== ex) begin
                n_bad++;
                $display("FAIL after_reset: got C=%0d n=%0d, want C=%0d n=%0d", obs.c, obs.n, ex.c, ex.n);
            end
        end
    endtask

    task automatic test_random();
        res_t obs, ex;
        int lat;
        bit ok;
        int primes [12] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 43, 59, 61};
        int pp, qq;
        longint unsigned ee, pt;
        for (int i = 0; i < 8; i++) begin
            pp = primes[$urandom_range(0, 11)];
            qq = primes[$urandom_range(0, 11)];
            ee = $urandom_range(0, 255);
            pt = $urandom_range(0, 2 * pp * qq);
            issue(pp, qq, ee, pt, model(pp, qq, ee, pt));
            collect(obs, lat, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL random_%0d_timeout: no done", i);
            end else begin
                ex = exp_q.pop_front();
                if (obs !== ex) begin
                    n_bad++;
                    $display("FAIL random_%0d p=%0d q=%0d e=%0d P=%0d: got err=%0d n=%0d phi=%0d C=%0d, want err=%0d n=%0d phi=%0d C=%0d",
                             i, pp, qq, ee, pt, obs.err, obs.n, obs.phi, obs.c, ex.err, ex.n, ex.phi, ex.c);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loopback();
        test_boundaries();
        test_err();
        test_range();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rsa_encrypt_seq.md
Name: rsa_encrypt_seq

Overview: Sequential RSA encryption engine, the transmit-side counterpart of the existing decryption path. Computes n = p*q and phi_n = (p-1)*(q-1) from the prime inputs, then C = P^e mod n using right-to-left square-and-multiply. Each modular multiply is an interleaved shift-add over WIDTH cycles, so no wide product or divider is built. Uses a start/busy/done handshake; the result feeds the decryption block for loopback checks.

Parameters:
WIDTH, 64, width of n, phi_n, P, e, C
PW, 9, width of each prime input p, q

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  synchronous active-low reset, sampled on clk rising edge
start  in  1  one-cycle request; accepted only in IDLE
p  in  PW  prime 1, sampled on accepted start
q  in  PW  prime 2, sampled on accepted start
e  in  WIDTH  public exponent, sampled on accepted start
P  in  WIDTH  plaintext, sampled on accepted start
busy  out  1  high from the cycle after accept until done
done  out  1  one-cycle pulse, C/n/phi_n/err valid
err  out  1  invalid operands, valid with done
n  out  WIDTH  modulus p*q, zero-extended
phi_n  out  WIDTH  totient (p-1)*(q-1), zero-extended
C  out  WIDTH  ciphertext

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; busy=0, done=0, err=0, n=0, phi_n=0, C=0. Reset wins over every other event, including mid-operation; no partial result is retained.
- States: IDLE -> SETUP -> BIT -> MUL -> SQR -> BIT ... -> DONE -> IDLE.
- IDLE: start=1 latches p, q, e, P and goes to SETUP. start while not IDLE is ignored and does not restart.
- SETUP (1 cycle): register n=p*q and phi_n=(p-1)*(q-1). err=1 if p<2 or q<2; then C=0, go to DONE.
- SETUP, valid operands: base = P mod n (see Optional Feature), res = 1 mod n (0 when n=1), exp = e.
- BIT (1 cycle): if exp==0, go to DONE with C=res. Else if exp[0]=1, go to MUL; otherwise go to SQR.
- MUL (WIDTH cycles): res = res*base mod n. Interleaved form, multiplier bits MSB first: acc = 2*acc mod n, then if bit set acc = acc + a mod n. acc is WIDTH+1 bits; each reduction is a single conditional subtract of n.
- SQR (WIDTH cycles): base = base*base mod n; exp = exp>>1; go to BIT.
- DONE (1 cycle): done=1; busy drops in the same cycle; return to IDLE.
- C, n, phi_n and err hold until the next accepted start. done is 0 outside DONE.
- Boundaries:
  - e=0 gives C=1 (C=0 when n=1).
  - P=0 with e>0 gives C=0.
  - The last SQR still executes (its result is discarded).
- Latency from start to done is data-dependent, at most 3 + k*(2*WIDTH+1) cycles, where k is the bit length of e.

Optional Feature:
RSA_RANGE_CHECK_EN
- Defined: in SETUP, P>=n sets err=1, C=0, and the engine goes straight to DONE with no exponentiation.
- Undefined: SETUP reduces P mod n with repeated conditional subtract of n (one subtract per cycle, SETUP stretched until base<n), and the operation completes normally with err=0.

Test Plan:
- p=61, q=53, e=17, P=65, start -> n=3233, phi_n=3120, C=2790, err=0, done one pulse, latency <= 3+5*129.
- p=3, q=11, e=7, P=2 -> n=33, phi_n=20, C=29. Feed C into the decryption block with d=3: recovers P=2.
- p=61, q=53, e=0, P=65 -> C=1. Same with P=0, e=17 -> C=0.
- p=1, q=53 -> err=1, C=0, done within 3 cycles.
- P=3300 with p=61, q=53, e=1:
  - with RSA_RANGE_CHECK_EN: err=1, C=0.
  - without: err=0, C=67.
- Start pulses while busy are ignored (result is still 2790 for the first request). Assert rst_n=0 mid-MUL -> next edge busy=0, C=0, n=0. A fresh start then computes correctly.
